// File: rtl/des_key_schedule_pipelined_if.sv
// Handshake and key bus between the key-schedule pipeline and the upstream block source.
// The master drives key material; the slave (the schedule) returns per-stage round keys.
interface des_key_schedule_pipelined_if;
  logic         enable;
  logic         i_valid;
  logic         decrypt;
  logic [1:64]  key_in;
  logic [1:768] Kn_bus;
  logic [1:16]  k_valid;

  modport master (
    output enable,
    output i_valid,
    output decrypt,
    output key_in,
    input  Kn_bus,
    input  k_valid
  );

  modport slave (
    input  enable,
    input  i_valid,
    input  decrypt,
    input  key_in,
    output Kn_bus,
    output k_valid
  );
endinterface

// File: rtl/des_key_schedule_pipelined.sv
// Sixteen-stage DES key schedule that runs in lock-step with the round pipeline.
// Each stage carries its own C/D halves and mode bit, so encrypt and decrypt blocks interleave freely.
module des_key_schedule_pipelined (
  input  logic                         clk,
  input  logic                         rst_n,
  des_key_schedule_pipelined_if.slave  bus
);

  function automatic logic [1:2] enc_amt(input int n);
    logic [1:2] a;
    case (n)
      1, 2, 9, 16: a = 2'd1;
      default:     a = 2'd2;
    endcase
    return a;
  endfunction

  function automatic logic [1:2] dec_amt(input int n);
    logic [1:2] a;
    case (n)
      1:           a = 2'd0;
      2, 9, 16:    a = 2'd1;
      default:     a = 2'd2;
    endcase
    return a;
  endfunction

  function automatic logic [1:28] rot28(input logic [1:28] c, input logic left, input logic [1:2] amt);
    logic [1:28] r;
    case ({left, amt})
      3'b101:  r = {c[2:28], c[1]};
      3'b110:  r = {c[3:28], c[1:2]};
      3'b001:  r = {c[28], c[1:27]};
      3'b010:  r = {c[27:28], c[1:26]};
      default: r = c;
    endcase
    return r;
  endfunction

  function automatic logic [1:56] stage_rot(input logic [1:56] cd, input logic dec,
                                            input logic [1:2] e_amt, input logic [1:2] d_amt);
    logic [1:2] amt;
    amt = dec ? d_amt : e_amt;
    return {rot28(cd[1:28], !dec, amt), rot28(cd[29:56], !dec, amt)};
  endfunction

  function automatic logic [1:56] pc1(input logic [1:64] k);
    return {k[57], k[49], k[41], k[33], k[25], k[17], k[9],
            k[1],  k[58], k[50], k[42], k[34], k[26], k[18],
            k[10], k[2],  k[59], k[51], k[43], k[35], k[27],
            k[19], k[11], k[3],  k[60], k[52], k[44], k[36],
            k[63], k[55], k[47], k[39], k[31], k[23], k[15],
            k[7],  k[62], k[54], k[46], k[38], k[30], k[22],
            k[14], k[6],  k[61], k[53], k[45], k[37], k[29],
            k[21], k[13], k[5],  k[28], k[20], k[12], k[4]};
  endfunction

  function automatic logic [1:48] pc2(input logic [1:56] c);
    return {c[14], c[17], c[11], c[24], c[1],  c[5],
            c[3],  c[28], c[15], c[6],  c[21], c[10],
            c[23], c[19], c[12], c[4],  c[26], c[8],
            c[16], c[7],  c[27], c[20], c[13], c[2],
            c[41], c[52], c[31], c[37], c[47], c[55],
            c[30], c[40], c[51], c[45], c[33], c[48],
            c[44], c[49], c[39], c[56], c[34], c[53],
            c[46], c[42], c[50], c[36], c[29], c[32]};
  endfunction

  logic [1:15][1:56] cd_q;
  logic [1:15][1:56] cd_d;
  logic [1:15]       mode_q;
  logic [1:15]       mode_d;
  logic [1:15]       v_q;
  logic [1:15]       v_d;

  logic [1:16][1:56] cd_in_s;
  logic [1:16][1:56] cd_out_s;
  logic [1:16]       mode_in_s;
  logic [1:768]      kn_bus_s;

  // Stage 1 takes PC-1 of the live key; later stages take the previous stage's register.
  assign cd_in_s   = {pc1(bus.key_in), cd_q};
  assign mode_in_s = {bus.decrypt, mode_q};

  for (genvar n = 1; n <= 16; n++) begin : g_stage
    localparam logic [1:2] E_AMT = enc_amt(n);
    localparam logic [1:2] D_AMT = dec_amt(n);
    assign cd_out_s[n]                    = stage_rot(cd_in_s[n], mode_in_s[n], E_AMT, D_AMT);
    assign kn_bus_s[48*(n-1)+1 +: 48]     = pc2(cd_out_s[n]);
  end

  assign cd_d   = cd_out_s[1:15];
  assign mode_d = mode_in_s[1:15];
  assign v_d    = {bus.i_valid, v_q[1:14]};

  assign bus.Kn_bus  = kn_bus_s;
  assign bus.k_valid = {bus.i_valid, v_q};

  // Valid shift register: reset discards every in-flight block and wins over a stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= 15'd0;
    end else if (bus.enable) begin
      v_q <= v_d;
    end else begin
      v_q <= v_q;
    end
  end

  // Key halves and mode travel with their block; contents are don't-care when not valid.
  always_ff @(posedge clk) begin
    if (bus.enable) begin
      cd_q   <= cd_d;
      mode_q <= mode_d;
    end else begin
      cd_q   <= cd_q;
      mode_q <= mode_q;
    end
  end

endmodule

// File: tb/tb_des_key_schedule_pipelined.sv
// Randomized and directed bench for the pipelined DES key schedule against a
// behavioural model that computes round keys from cumulative rotation totals.
module tb_des_key_schedule_pipelined;

  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
                                23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48,
                                44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  logic clk;
  logic rst_n;
  des_key_schedule_pipelined_if bif ();

  des_key_schedule_pipelined dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  bit          cur_en, cur_v, cur_dec, cur_rstn;
  logic [63:0] cur_key;
  bit          mv [17];
  bit          md [17];
  logic [63:0] mk [17];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Round key K(r) from first principles: Cr/Dr are C0/D0 rotated left by the running shift total.
  function automatic logic [47:0] ref_key(input logic [63:0] key, input bit dec, input int n);
    int          r;
    int          s;
    longint      c;
    longint      d;
    logic [55:0] cd;
    logic [47:0] k;
    r = dec ? 17 - n : n;
    s = 0;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = longint'(cd[55:28]);
    d = longint'(cd[27:0]);
    for (int i = 0; i < r; i++) s += SHIFTS[i];
    s = s % 28;
    c = ((c << s) | (c >> (28 - s))) & 64'h0FFF_FFFF;
    d = ((d << s) | (d >> (28 - s))) & 64'h0FFF_FFFF;
    cd = {c[27:0], d[27:0]};
    for (int j = 0; j < 48; j++) k[47-j] = cd[56-PC2_T[j]];
    return k;
  endfunction

  function automatic logic [47:0] slice_of(input int n);
    logic [767:0] f;
    f = bif.Kn_bus;
    return f[768-48*n +: 48];
  endfunction

  function automatic bit kv_of(input int n);
    logic [15:0] kv;
    kv = bif.k_valid;
    return kv[16-n];
  endfunction

  task automatic check_outputs();
    bit          ev;
    bit          ed;
    logic [63:0] ek;
    for (int n = 1; n <= 16; n++) begin
      ev = (n == 1) ? cur_v   : mv[n];
      ed = (n == 1) ? cur_dec : md[n];
      ek = (n == 1) ? cur_key : mk[n];
      check_eq($sformatf("k_valid[%0d]", n), 64'(kv_of(n)), 64'(ev));
      if (ev) check_eq($sformatf("slice%0d", n), 64'(slice_of(n)), 64'(ref_key(ek, ed, n)));
    end
  endtask

  task automatic drive_check(input bit en, input bit v, input bit dec, input logic [63:0] key, input bit rstn);
    cur_en = en; cur_v = v; cur_dec = dec; cur_key = key; cur_rstn = rstn;
    bif.enable = en; bif.i_valid = v; bif.decrypt = dec; bif.key_in = key; rst_n = rstn;
    @(negedge clk);
    if (chk_on) check_outputs();
  endtask

  task automatic advance();
    @(posedge clk);
    if (cur_en) begin
      for (int n = 16; n >= 3; n--) begin
        mv[n] = mv[n-1]; md[n] = md[n-1]; mk[n] = mk[n-1];
      end
      mv[2] = cur_v; md[2] = cur_dec; mk[2] = cur_key;
    end
    if (!cur_rstn) for (int n = 2; n <= 16; n++) mv[n] = 1'b0;
    #1;
  endtask

  localparam logic [63:0] KEY_A = 64'h1334_5779_9BBC_DFF1;
  localparam logic [63:0] KEY_W = 64'h0101_0101_0101_0101;

  initial begin
    logic [63:0] rk;
    for (int n = 0; n <= 16; n++) begin mv[n] = 1'b0; md[n] = 1'b0; mk[n] = 64'd0; end
    bif.enable = 1'b0; bif.i_valid = 1'b0; bif.decrypt = 1'b0; bif.key_in = 64'd0; rst_n = 1'b0;
    @(posedge clk); #1;
    repeat (2) begin drive_check(1'b1, 1'b0, 1'b0, 64'd0, 1'b0); advance(); end
    chk_on = 1'b1;
    drive_check(1'b1, 1'b0, 1'b0, 64'd0, 1'b1); advance();

    // Encrypt known-answer walk.
    for (int i = 0; i <= 16; i++) begin
      drive_check(1'b1, i == 0, 1'b0, KEY_A, 1'b1);
      if (i == 0)  check_eq("enc_k1",  64'(slice_of(1)),  64'h1B02EFFC7072);
      if (i == 1)  check_eq("enc_k2",  64'(slice_of(2)),  64'h79AED9DBC9E5);
      if (i == 15) check_eq("enc_k16", 64'(slice_of(16)), 64'hCB3D8B0E17F5);
      advance();
    end

    // Decrypt known-answer walk.
    for (int i = 0; i <= 16; i++) begin
      drive_check(1'b1, i == 0, 1'b1, KEY_A, 1'b1);
      if (i == 0)  check_eq("dec_s1",  64'(slice_of(1)),  64'hCB3D8B0E17F5);
      if (i == 15) check_eq("dec_s16", 64'(slice_of(16)), 64'h1B02EFFC7072);
      advance();
    end

    // Weak key in both modes: every valid slice is all zeros.
    for (int i = 0; i <= 18; i++) begin
      drive_check(1'b1, i < 2, i == 1, KEY_W, 1'b1);
      for (int n = 1; n <= 16; n++)
        if (kv_of(n)) check_eq($sformatf("weak_s%0d", n), 64'(slice_of(n)), 64'd0);
      advance();
    end

    // Alternating encrypt/decrypt with random keys, then drain.
    for (int i = 0; i < 48; i++) begin
      rk = {$urandom, $urandom};
      drive_check(1'b1, i < 32, i[0], rk, 1'b1);
      advance();
    end

    // Three-cycle stall while the known block sits in stage 6.
    for (int i = 0; i <= 20; i++) begin
      drive_check(!(i >= 5 && i <= 7), i == 0, 1'b0, KEY_A, 1'b1);
      if (i >= 5 && i <= 8) check_eq("stall_k6", 64'(slice_of(6)), 64'(ref_key(KEY_A, 1'b0, 6)));
      if (i == 18) begin
        check_eq("stall_v16", 64'(kv_of(16)), 64'd1);
        check_eq("stall_k16", 64'(slice_of(16)), 64'hCB3D8B0E17F5);
      end
      advance();
    end

    // Reset with eight blocks in flight, then a fresh block.
    for (int i = 0; i <= 25; i++) begin
      rk = {$urandom, $urandom};
      drive_check(1'b1, i <= 8, rk[0], rk, i != 7);
      if (i == 8) check_eq("rst_flush", 64'(bif.k_valid[2:16]), 64'd0);
      advance();
    end

    // Fully random traffic with stalls and occasional resets.
    for (int i = 0; i < 200; i++) begin
      rk = {$urandom, $urandom};
      drive_check($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  rk, $urandom_range(0, 39) != 0);
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_key_schedule_pipelined.md
# des_key_schedule_pipelined

Pipelined DES key schedule that generates the sixteen 48-bit round keys directly upstream of the 16-stage pipelined round-function chain. Each key emerges in the same cycle that its round stage samples L/R. The schedule advances one stage per accepted cycle alongside the data, so every block in flight carries its own key and mode. Encryption (left-rotate) and decryption (right-rotate, reversed key order) can be interleaved cycle by cycle.

## Interface
- No parameters; the 16-round DES structure is fixed.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- enable  input  1  global pipeline advance; when 0 every register holds, shared with the round chain.
- i_valid  input  1  key_in/decrypt valid this cycle; qualifies round 1.
- decrypt  input  1  0 = encrypt schedule, 1 = decrypt schedule.
- key_in  input  [1:64]  64-bit DES key, bit 1 = MSB; parity bits 8,16,…,64 ignored.
- Kn_bus  output  [1:768]  round keys per stage; bits [48(n-1)+1 : 48n] = key for round stage n (n = 1..16).
- k_valid  output  [1:16]  k_valid[n] = key slice n belongs to a valid block.

## Operation
- Stage 0, combinational: C0D0 = PC-1(key_in), 28+28 bits.
- Encrypt rotate-left amounts for rounds 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Decrypt rotate-right amounts for rounds 1..16: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Round n, n = 1..16: CnDn = rotate(C(n-1), D(n-1)) by amount n in the direction selected by the stage's mode bit. Kn_bus slice n = PC-2(CnDn), combinational from the stage's registered input (stage 1 from key_in).
- Round-key order:
  - Encrypt: slice n = Kn.
  - Decrypt: slice n = K(17-n). Slice 1 = PC-2(C0D0) = K16.
- Pipeline registers cd_reg[n] (56 b), mode_reg[n], and v_reg[n] for n = 1..15.
  - On clk with enable = 1: cd_reg[1] <= C1D1 from key_in; cd_reg[n] <= CnDn computed from cd_reg[n-1]. Mode and valid shift the same way, with v_reg[1] <= i_valid.
- Key and mode registers load on every enabled cycle regardless of valid. No datapath reset; their contents are don't-care while the matching valid is 0.
- k_valid[1] = i_valid, combinational. k_valid[n] = v_reg[n-1] for n = 2..16.
- enable = 0: all registers hold. Kn_bus and k_valid stay stable because they depend only on held registers, except slice 1 and k_valid[1], which follow the inputs.
- Reset: when rst_n = 0 at a clock edge, v_reg[1..15] <= 0. Reset has priority over enable. Key and mode registers are not reset.

## Timing
- Block accepted at cycle t (i_valid = 1, enable = 1): its key for round n is presented during cycle t+n-1, assuming enable stays high. Each enable = 0 cycle adds one cycle of delay uniformly.
- Throughput: one key set per enabled cycle; no backpressure output.
- Critical path: one stage's rotate mux, 2:1 on direction plus fixed amount, feeding PC-2. PC-1 adds to stage 1 only.
- After reset release: k_valid[2..16] = 0 until new blocks propagate. k_valid[1] mirrors i_valid immediately.
- Reset mid-stream: all in-flight blocks are discarded on the reset edge. The block presented in the cycle after reset release is handled normally.
- Simultaneous enable = 0 and rst_n = 0: valids clear, other registers hold.

## Test plan
- Encrypt, key 133457799BBCDFF1, i_valid for 1 cycle at t:
  - cycle t: slice 1 = 1B02EFFC7072.
  - cycle t+1: slice 2 = 79AED9DBC9E5.
  - cycle t+15: slice 16 = CB3D8B0E17F5.
  - k_valid one-hot walks 1→16.
- Decrypt, same key: slice 1 = CB3D8B0E17F5 at t; slice 16 = 1B02EFFC7072 at t+15.
- Weak key 0101010101010101, both modes: every slice = 000000000000 when its k_valid is high.
- Interleave enc/dec on alternating cycles for 32 cycles with random keys: every slice matches a software model per block; no cross-contamination of mode.
- enable = 0 for 3 cycles at t+5 with the block from the first test: slice 6 = K6 is held through the stall, k_valid holds, completion shifts to t+18.
- rst_n = 0 for 1 cycle at t+7 with 8 blocks in flight: k_valid[2..16] = 0 on the next cycle. A new block at t+8 yields correct K1..K16 at t+8..t+23.
